// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared definitions for the multi-cycle MIPS-subset core.
//   - opcode / funct encodings of the supported instructions
//   - FSM state encoding (3 bits)
//   - ALU control codes, the ALU-control decode function and the legality check
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctl_t;

  // I-type instructions (addi/lw/sw) all use the adder; beq compares A/B directly.
  function automatic alu_ctl_t alu_decode(input logic [5:0] op, input logic [5:0] funct);
    alu_ctl_t ctl;
    ctl = ALU_ADD;
    if (op == OP_RTYPE) begin
      case (funct)
        FN_SUB:  ctl = ALU_SUB;
        FN_AND:  ctl = ALU_AND;
        FN_OR:   ctl = ALU_OR;
        FN_SLT:  ctl = ALU_SLT;
        default: ctl = ALU_ADD;
      endcase
    end
    return ctl;
  endfunction

  function automatic logic insn_legal(input logic [5:0] op, input logic [5:0] funct);
    logic ok;
    case (op)
      OP_RTYPE: ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mips_mc_regfile.sv
// mips_mc_regfile: 32 x 32-bit general purpose register file.
//   clk, reset       : clock, synchronous active-high reset (all GPRs <= REG_INIT)
//   ra_a/rdata_a     : asynchronous read port A
//   ra_b/rdata_b     : asynchronous read port B
//   we/wa/wd         : synchronous write port; writes to $0 are discarded
// $0 always reads as zero regardless of its stored value.
module mips_mc_regfile #(
  parameter logic [31:0] REG_INIT = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  ra_b,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= REG_INIT;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rdata_a = (ra_a == 5'd0) ? 32'd0 : regs[ra_a];
  assign rdata_b = (ra_b == 5'd0) ? 32'd0 : regs[ra_b];

endmodule

// File: rtl/mips_mc_core.sv
// mips_mc_core: multi-cycle MIPS-subset core (add/sub/and/or/slt, addi, lw, sw, beq, j).
// One instruction is sequenced over FETCH -> DECODE -> EXEC -> {MEM, WB} with a shared ALU.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   i_req/i_addr/i_rdata/i_ready   : instruction fetch handshake (i_addr = PC)
//   d_req/d_we/d_addr/d_wdata/
//   d_rdata/d_ready                : data access handshake (d_we=1 store, 0 load)
//   pc                             : current PC
//   trap                           : sticky illegal-instruction flag
//   retired                        : one-cycle pulse on the last cycle of each instruction
//   cyc_cnt, ins_cnt               : performance counters
// Configuration macro MIPS_MC_PERF_EN: when defined, cyc_cnt counts cycles out of reset and
// ins_cnt counts retired instructions (both wrap); when undefined both outputs are tied to 0.
module mips_mc_core
  import mips_mc_pkg::*;
#(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [31:0]        REG_INIT = 32'd0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              i_req,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_rdata,
  input  logic              i_ready,
  output logic              d_req,
  output logic              d_we,
  output logic [ADDR_W-1:0] d_addr,
  output logic [31:0]       d_wdata,
  input  logic [31:0]       d_rdata,
  input  logic              d_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              trap,
  output logic              retired,
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       ins_cnt
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir, a_q, b_q, alu_out, mdr;
  logic              trap_q;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] se_imm;
  logic        legal, i_done, d_done;

  assign op     = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign se_imm = {{16{ir[15]}}, ir[15:0]};
  assign legal  = insn_legal(op, funct);

  // Handshakes only complete while the matching request is up, so stray readies are ignored.
  assign i_done = i_req & i_ready;
  assign d_done = d_req & d_ready;

  // Register file
  logic [31:0] rs_val, rt_val, wb_data;
  logic [4:0]  wb_addr;
  logic        wb_en;

  assign wb_en   = (state == ST_WB);
  assign wb_addr = (op == OP_RTYPE) ? rd : rt;
  assign wb_data = (op == OP_LW) ? mdr : alu_out;

  mips_mc_regfile #(.REG_INIT(REG_INIT)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .ra_a    (rs),
    .rdata_a (rs_val),
    .ra_b    (rt),
    .rdata_b (rt_val),
    .we      (wb_en),
    .wa      (wb_addr),
    .wd      (wb_data)
  );

  // ALU: operands are declared signed so slt is a two's-complement compare.
  alu_ctl_t           alu_ctl;
  logic signed [31:0] alu_a, alu_b;
  logic [31:0]        alu_res;

  always_comb begin
    alu_ctl = alu_decode(op, funct);
    alu_a   = a_q;
    alu_b   = (op == OP_RTYPE) ? b_q : se_imm;
    case (alu_ctl)
      ALU_SUB: alu_res = alu_a - alu_b;
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_OR:  alu_res = alu_a | alu_b;
      ALU_SLT: alu_res = {31'd0, (alu_a < alu_b)};
      default: alu_res = alu_a + alu_b;
    endcase
  end

  // PC targets. The jump keeps PC[31:28] only when the PC is that wide; narrower PCs
  // zero-extend here, so the upper nibble is simply truncated away.
  logic [31:0]       pc_ext, jmp_full, br_off;
  logic [ADDR_W-1:0] pc_plus4, br_target;

  assign pc_ext    = 32'(pc_q);
  assign jmp_full  = {pc_ext[31:28], ir[25:0], 2'b00};
  assign br_off    = se_imm << 2;
  assign pc_plus4  = pc_q + ADDR_W'(4);
  assign br_target = pc_q + br_off[ADDR_W-1:0];

  logic unused_bits;
  assign unused_bits = ^{ir[10:6], alu_out[31:ADDR_W], jmp_full[31:ADDR_W],
                         br_off[31:ADDR_W], pc_ext[27:0]};

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_FETCH:  if (i_done) state_nx = ST_DECODE;
      ST_DECODE: begin
        if (!legal)           state_nx = ST_TRAP;
        else if (op == OP_J)  state_nx = ST_FETCH;
        else                  state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        if (op == OP_LW || op == OP_SW) state_nx = ST_MEM;
        else if (op == OP_BEQ)          state_nx = ST_FETCH;
        else                            state_nx = ST_WB;
      end
      ST_MEM:    if (d_done) state_nx = (op == OP_LW) ? ST_WB : ST_FETCH;
      ST_WB:     state_nx = ST_FETCH;
      ST_TRAP:   state_nx = ST_TRAP;
      default:   state_nx = ST_FETCH;
    endcase
  end

  // Requests depend only on registered state (no ready->req path); held low during reset.
  always_comb begin
    i_req   = 1'b0;
    d_req   = 1'b0;
    retired = 1'b0;
    if (!reset) begin
      i_req = (state == ST_FETCH);
      d_req = (state == ST_MEM);
      case (state)
        ST_DECODE: retired = legal && (op == OP_J);
        ST_EXEC:   retired = (op == OP_BEQ);
        ST_MEM:    retired = d_ready && (op == OP_SW);
        ST_WB:     retired = 1'b1;
        default:   retired = 1'b0;
      endcase
    end
  end

  assign i_addr  = pc_q;
  assign pc      = pc_q;
  assign d_we    = d_req && (op == OP_SW);
  assign d_addr  = alu_out[ADDR_W-1:0];
  assign d_wdata = b_q;
  assign trap    = trap_q;

  // Control state: FSM, PC, trap flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_FETCH;
      pc_q   <= RESET_PC;
      trap_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_FETCH && i_done)
        pc_q <= pc_plus4;
      else if (state == ST_DECODE && legal && op == OP_J)
        pc_q <= jmp_full[ADDR_W-1:0];
      else if (state == ST_EXEC && op == OP_BEQ && a_q == b_q)
        pc_q <= br_target;
      if (state == ST_DECODE && !legal)
        trap_q <= 1'b1;
    end
  end

  // Datapath registers: IR, A/B, ALUOut, MDR
  always_ff @(posedge clk) begin
    if (reset) begin
      ir      <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      alu_out <= 32'd0;
      mdr     <= 32'd0;
    end else begin
      case (state)
        ST_FETCH:  if (i_done) ir <= i_rdata;
        ST_DECODE: begin
          a_q <= rs_val;
          b_q <= rt_val;
        end
        ST_EXEC:   alu_out <= alu_res;
        ST_MEM:    if (d_done && op == OP_LW) mdr <= d_rdata;
        default:   ;
      endcase
    end
  end

`ifdef MIPS_MC_PERF_EN
  logic [31:0] cyc_q, ins_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q <= 32'd0;
      ins_q <= 32'd0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (retired) ins_q <= ins_q + 32'd1;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ins_cnt = ins_q;
`else
  assign cyc_cnt = 32'd0;
  assign ins_cnt = 32'd0;
`endif

endmodule
